vid_stream_framer: RTL and testbench

Front end of the pixel-processing chain. Converts raw sensor/HDMI video timing (data-enable plus vertical sync) into the framed stream the radial-gain stages consume: per-pixel valid, 11-bit horizontal/vertical coordinates, and an end-of-frame pulse. Also checks frame geometry, drops out-of-bounds pixels, and reports sticky error flags so downstream coordinate math never sees bad coordinates.

---
 rtl/vid_stream_pkg.sv | 21 ++
 rtl/vid_edge_det.sv | 20 ++
 rtl/vid_stream_framer.sv | 172 +++++++++++++++++
 tb/tb_vid_stream_framer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_stream_pkg.sv
// rtl/vid_stream_pkg.sv - shared video geometry defaults, coordinate width and framer state type
package vid_stream_pkg;

  localparam int IMG_WIDTH_DEF  = 1280;
  localparam int IMG_HEIGHT_DEF = 720;
  localparam int COORD_W        = 11;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    ST_WAIT_SOF,
    ST_ACTIVE,
    ST_DONE
  } framer_state_e;

  // Counters saturate so a runaway line can never wrap back into the valid range.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] x);
    return (x == COORD_MAX) ? x : x + 1'b1;
  endfunction

endpackage

// File: rtl/vid_edge_det.sv
// rtl/vid_edge_det.sv - rise/fall detector against a one-cycle registered copy of the input
module vid_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/vid_stream_framer.sv
// rtl/vid_stream_framer.sv - DE/VS timing to framed pixel stream with geometry checks
// Optional error counters: VID_FRAMER_ERR_CNT_EN
module vid_stream_framer
  import vid_stream_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int DATA_WIDTH = 8,
  parameter int VS_POL     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vs_i,
  input  logic                  de_i,
  input  logic [DATA_WIDTH-1:0] r_i,
  input  logic [DATA_WIDTH-1:0] g_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  clr_err_i,
  output logic                  valid_o,
  output logic                  eof_o,
  output logic [COORD_W-1:0]    h_cnt_o,
  output logic [COORD_W-1:0]    v_cnt_o,
  output logic [DATA_WIDTH-1:0] r_o,
  output logic [DATA_WIDTH-1:0] g_o,
  output logic [DATA_WIDTH-1:0] b_o,
`ifdef VID_FRAMER_ERR_CNT_EN
  output logic [15:0]           line_err_cnt_o,
  output logic [15:0]           frame_err_cnt_o,
`endif
  output logic                  line_err_o,
  output logic                  frame_err_o
);

  localparam logic [COORD_W-1:0] W_C    = COORD_W'(IMG_WIDTH);
  localparam logic [COORD_W-1:0] H_C    = COORD_W'(IMG_HEIGHT);
  localparam logic [COORD_W-1:0] LAST_H = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_V = COORD_W'(IMG_HEIGHT - 1);

  logic vs_act, vs_rise, de_fall;
  logic unused_edges_rise, unused_edges_fall;

  assign vs_act = (VS_POL != 0) ? vs_i : ~vs_i;

  vid_edge_det u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (vs_act),
    .rise_o (vs_rise),
    .fall_o (unused_edges_fall)
  );

  vid_edge_det u_de_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (de_i),
    .rise_o (unused_edges_rise),
    .fall_o (de_fall)
  );

  framer_state_e      state_q, state_d, cur_state;
  logic [COORD_W-1:0] h_q, h_d, cur_h;
  logic [COORD_W-1:0] v_q, v_d, cur_v;
  logic               fwd_d, eof_d, line_set, frame_set;

  // A vs edge restarts the frame before this cycle's pixel is classified.
  assign cur_state = vs_rise ? ST_ACTIVE : state_q;
  assign cur_h     = vs_rise ? '0 : h_q;
  assign cur_v     = vs_rise ? '0 : v_q;

  always_comb begin
    state_d   = cur_state;
    h_d       = cur_h;
    v_d       = cur_v;
    fwd_d     = 1'b0;
    eof_d     = 1'b0;
    line_set  = 1'b0;
    frame_set = vs_rise && (state_q == ST_ACTIVE) && ((h_q != '0) || (v_q != '0));
    case (cur_state)
      ST_ACTIVE: begin
        if (de_i) begin
          h_d = sat_inc(cur_h);
          if (cur_h >= W_C) line_set = 1'b1;
          if (cur_v >= H_C) frame_set = 1'b1;
          if ((cur_h < W_C) && (cur_v < H_C)) begin
            fwd_d = 1'b1;
            if ((cur_h == LAST_H) && (cur_v == LAST_V)) begin
              eof_d   = 1'b1;
              state_d = ST_DONE;
            end
          end
        end else if (de_fall && !vs_rise) begin
          line_set = (cur_h != W_C);
          h_d      = '0;
          v_d      = sat_inc(cur_v);
        end
      end
      ST_DONE: begin
        if (de_i) frame_set = 1'b1;
      end
      default: ;
    endcase
  end

  logic                  valid_q, eof_q, line_err_q, frame_err_q;
  logic [COORD_W-1:0]    h_out_q, v_out_q;
  logic [DATA_WIDTH-1:0] r_q, g_q, b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WAIT_SOF;
      h_q         <= '0;
      v_q         <= '0;
      valid_q     <= 1'b0;
      eof_q       <= 1'b0;
      h_out_q     <= '0;
      v_out_q     <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      valid_q     <= fwd_d;
      eof_q       <= eof_d;
      r_q         <= r_i;
      g_q         <= g_i;
      b_q         <= b_i;
      if (fwd_d) begin
        h_out_q <= cur_h;
        v_out_q <= cur_v;
      end
      line_err_q  <= clr_err_i ? 1'b0 : (line_err_q | line_set);
      frame_err_q <= clr_err_i ? 1'b0 : (frame_err_q | frame_set);
    end
  end

  assign valid_o     = valid_q;
  assign eof_o       = eof_q;
  assign h_cnt_o     = h_out_q;
  assign v_cnt_o     = v_out_q;
  assign r_o         = r_q;
  assign g_o         = g_q;
  assign b_o         = b_q;
  assign line_err_o  = line_err_q;
  assign frame_err_o = frame_err_q;

`ifdef VID_FRAMER_ERR_CNT_EN
  logic [15:0] line_cnt_q, frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else if (clr_err_i) begin
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (line_set && (line_cnt_q != 16'hFFFF))   line_cnt_q  <= line_cnt_q + 16'd1;
      if (frame_set && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign line_err_cnt_o  = line_cnt_q;
  assign frame_err_cnt_o = frame_cnt_q;
`else
  // Event counters compiled out; the sticky flags above remain the only error report.
`endif

endmodule

// File: tb/tb_vid_stream_framer.sv
// tb/tb_vid_stream_framer.sv - scoreboard bench for vid_stream_framer on an 8x4 geometry
module tb_vid_stream_framer;

  localparam int W = 8;
  localparam int H = 4;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        eof;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst, vs, de, clr;
  logic [7:0]  r, g, b;
  logic        valid_o, eof_o, line_err_o, frame_err_o;
  logic [10:0] h_cnt_o, v_cnt_o;
  logic [7:0]  r_o, g_o, b_o;
`ifdef VID_FRAMER_ERR_CNT_EN
  logic [15:0] line_err_cnt_o, frame_err_cnt_o;
`endif

  int   errors = 0;
  int   checks = 0;
  pix_t exp_q[$];
  int   lens[H];
  int   nlines;
  bit   vs_with_de;

  always #5 clk = ~clk;

  vid_stream_framer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_WIDTH (8),
    .VS_POL     (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .vs_i            (vs),
    .de_i            (de),
    .r_i             (r),
    .g_i             (g),
    .b_i             (b),
    .clr_err_i       (clr),
    .valid_o         (valid_o),
    .eof_o           (eof_o),
    .h_cnt_o         (h_cnt_o),
    .v_cnt_o         (v_cnt_o),
    .r_o             (r_o),
    .g_o             (g_o),
    .b_o             (b_o),
`ifdef VID_FRAMER_ERR_CNT_EN
    .line_err_cnt_o  (line_err_cnt_o),
    .frame_err_cnt_o (frame_err_cnt_o),
`endif
    .line_err_o      (line_err_o),
    .frame_err_o     (frame_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented pixel must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (eof_o && !valid_o) begin
        checks++;
        errors++;
        $display("FAIL eof_without_valid: eof_o=1 valid_o=0");
      end
      if (valid_o) begin
        pix_t act, exp;
        act = {h_cnt_o, v_cnt_o, r_o, g_o, b_o, eof_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got h=%0d v=%0d eof=%0b with nothing expected",
                   h_cnt_o, v_cnt_o, eof_o);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL pixel: got h=%0d v=%0d rgb=%h%h%h eof=%0b expected h=%0d v=%0d rgb=%h%h%h eof=%0b",
                     act.h, act.v, act.r, act.g, act.b, act.eof,
                     exp.h, exp.v, exp.r, exp.g, exp.b, exp.eof);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    step(); vs = 1'b1;
    step();
    step(); vs = 1'b0;
    step();
  endtask

  task automatic send_line(input int l);
    for (int p = 0; p < lens[l]; p++) begin
      pix_t e;
      step();
      de = 1'b1;
      vs = (vs_with_de && l == 0 && p == 0);
      r  = 8'($urandom);
      g  = 8'($urandom);
      b  = 8'($urandom);
      if (p < W && l < H) begin
        e.h = 11'(p); e.v = 11'(l);
        e.r = r; e.g = g; e.b = b;
        e.eof = (p == W - 1) && (l == H - 1);
        exp_q.push_back(e);
      end
    end
    step(); de = 1'b0; vs = 1'b0;
    step();
    step();
  endtask

  // Expected errors come from line lengths alone: a frame is good only if it
  // reaches its last pixel, every line before that is exactly W long, and the
  // last line carries no extra pixels.
  task automatic run_frame(input string tag);
    int lc, fc;
    bit eof_ok;
    step(); clr = 1'b1;
    step(); clr = 1'b0;
    step();
    chk({tag, "_line_err_cleared"}, 32'(line_err_o), 0);
    chk({tag, "_frame_err_cleared"}, 32'(frame_err_o), 0);
    if (!vs_with_de) vs_pulse();
    for (int l = 0; l < nlines; l++) send_line(l);
    vs_pulse();
    step(); step();
    eof_ok = (nlines == H) && (lens[H-1] >= W);
    lc = 0;
    fc = eof_ok ? 0 : 1;
    for (int l = 0; l < nlines; l++) begin
      if (eof_ok && l == H - 1)  fc += lens[l] - W;
      else if (lens[l] > W)      lc += lens[l] - W + 1;
      else if (lens[l] < W)      lc += 1;
    end
    chk({tag, "_line_err"}, 32'(line_err_o), 32'(lc > 0));
    chk({tag, "_frame_err"}, 32'(frame_err_o), 32'(fc > 0));
`ifdef VID_FRAMER_ERR_CNT_EN
    chk({tag, "_line_err_cnt"}, 32'(line_err_cnt_o), 32'(lc));
    chk({tag, "_frame_err_cnt"}, 32'(frame_err_cnt_o), 32'(fc));
`endif
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 0);
    vs_with_de = 1'b0;
  endtask

  task automatic set_lens(input int a, input int b2, input int c, input int d, input int n);
    lens[0] = a; lens[1] = b2; lens[2] = c; lens[3] = d; nlines = n;
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; de = 1'b0; clr = 1'b0;
    r = '0; g = '0; b = '0;
    vs_with_de = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_eof", 32'(eof_o), 0);
    chk("rst_h", 32'(h_cnt_o), 0);
    chk("rst_v", 32'(v_cnt_o), 0);
    chk("rst_rgb", {8'd0, r_o, g_o, b_o}, 0);
    chk("rst_line_err", 32'(line_err_o), 0);
    chk("rst_frame_err", 32'(frame_err_o), 0);
    step(); rst = 1'b0;

    // de activity before the first vs edge is ignored.
    lens[0] = W;
    for (int p = 0; p < W; p++) begin step(); de = 1'b1; end
    step(); de = 1'b0;
    step();
    chk("pre_sof_line_err", 32'(line_err_o), 0);

    set_lens(W, W, W, W, 4);         run_frame("clean");
    set_lens(W, W + 1, W, W, 4);     run_frame("long_line");
    set_lens(W, W, W, W, 2);         run_frame("short_frame");
    set_lens(W, W, W, W, 4);
    vs_with_de = 1'b1;               run_frame("vs_with_de");
    set_lens(W - 2, W - 1, W - 3, W, 4); run_frame("three_short");
    set_lens(W, W, W, W + 2, 4);     run_frame("long_last_line");

    // Reset mid-line around pixel (3,1): outputs clear, rest of frame suppressed.
    step(); vs_pulse();
    lens[0] = W;
    send_line(0);
    for (int p = 0; p < 4; p++) begin
      pix_t e;
      step(); de = 1'b1;
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      e.h = 11'(p); e.v = 11'd1; e.r = r; e.g = g; e.b = b; e.eof = 1'b0;
      exp_q.push_back(e);
    end
    step(); r = 8'hA5;
    step(); rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(valid_o), 0);
    chk("midrst_h", 32'(h_cnt_o), 0);
    chk("midrst_v", 32'(v_cnt_o), 0);
    chk("midrst_rgb", {8'd0, r_o, g_o, b_o}, 0);
    step(); rst = 1'b0;
    for (int p = 0; p < 2 * W + 3; p++) begin
      step(); de = (p % (W + 3)) < W;
    end
    step(); de = 1'b0;
    step();
    chk("midrst_line_err", 32'(line_err_o), 0);
    chk("midrst_frame_err", 32'(frame_err_o), 0);
    chk("midrst_queue", 32'(exp_q.size()), 0);
    set_lens(W, W, W, W, 4);         run_frame("after_rst");

    for (int i = 0; i < 12; i++) begin
      nlines = ($urandom_range(0, 1) == 0) ? H : int'($urandom_range(1, H));
      for (int l = 0; l < H; l++)
        lens[l] = ($urandom_range(0, 9) < 6) ? W : int'($urandom_range(W - 3, W + 2));
      run_frame($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
